// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_tx_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } tx_state_t;
`endif

  function automatic logic [31:0] clamp_div(
    input logic [31:0] clk_div,
    input logic [31:0] min_div
  );
    return (clk_div < min_div) ? min_div : clk_div;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Read data is the current head, valid whenever empty is low.
module uart_tx_sync_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter: byte FIFO feeding an LSB-first 8N1 serialiser.
// Define UART_TX_PARITY_EN for an even-parity bit (11 bit-time frames).
module uart_tx_fifo_ctrl
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int MIN_DIV    = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic [LW-1:0]    fifo_level
);

  localparam logic [DIV_W-1:0] CNT_ONE = 1;

  tx_state_t        state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_new;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             avail_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             bit_end;
  logic             can_start;
  logic             pop;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  uart_tx_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clock    (clock),
    .resetb   (resetb),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign div_new   = DIV_W'(clamp_div(32'(clk_div), 32'(MIN_DIV)));
  assign bit_end   = (cnt == '0);
  // avail_q delays the FIFO-ready view by one cycle before a frame may start
  assign can_start = enable && avail_q && !fifo_empty;

  always_comb begin
    pop = 1'b0;
    if (state == IDLE && can_start) pop = 1'b1;
    if (state == STOP && bit_end && can_start) pop = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      avail_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      avail_q <= !fifo_empty;
      if (pop) begin
        state   <= START;
        tx      <= 1'b0;
        shreg   <= fifo_data;
        div_q   <= div_new;
        cnt     <= div_new - CNT_ONE;
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^fifo_data;
`endif
      end else if (state != IDLE) begin
        if (!bit_end) begin
          cnt <= cnt - CNT_ONE;
        end else begin
          cnt <= div_q - CNT_ONE;
          unique case (state)
            START: begin
              state <= DATA;
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
            DATA: begin
              if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                tx    <= par_q;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx      <= shreg[0];
                shreg   <= shreg >> 1;
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state <= STOP;
              tx    <= 1'b1;
            end
`endif
            STOP:    state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl.
// A negedge line monitor checks every cycle of each frame against a scoreboard.
module tb_uart_tx_fifo_ctrl;

  logic        clock = 1'b0;
  logic        resetb;
  logic        enable;
  logic [15:0] clk_div;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_level;

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         gap0;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          last_end = 0;
  int          nframes = 0;
  int          n0;
  bit          mon_act = 1'b0;
  int          bitn = 0;
  int          k = 0;
  int          nb = 10;
  logic [10:0] fb;

  uart_tx_fifo_ctrl dut (
    .clock     (clock),
    .resetb    (resetb),
    .enable    (enable),
    .clk_div   (clk_div),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input int div, input bit gap0);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    chk("push_rdy", 32'(in_ready), 32'd1);
    e.d = d;
    e.div = div;
    e.gap0 = gap0;
    sb.push_back(e);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (sb.size() == 0 && !mon_act && !busy) return;
      tick;
    end
    chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bit(input int b);
    for (int i = 0; i < 2000; i++) begin
      if (mon_act && bitn >= b) return;
      tick;
    end
    chk("wait_bit_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_lvl_change(input logic [3:0] prev);
    for (int i = 0; i < 500; i++) begin
      if (fifo_level != prev) return;
      tick;
    end
    chk("wait_lvl_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (nframes >= n) return;
      tick;
    end
    chk("wait_frame_timeout", 32'd0, 32'd1);
  endtask

  // Line monitor: every cycle of a frame is compared with its expected bit
  always @(negedge clock) begin
    if (!resetb) begin
      mon_act = 1'b0;
    end else begin
      if (!mon_act && tx === 1'b0) begin
        if (sb.size() == 0) begin
          chk("spurious_start", 32'(tx), 32'd1);
        end else begin
          cur = sb.pop_front();
          if (cur.gap0) chk("stop_start_gap", cyc - last_end - 1, 32'd0);
          fb = '1;
          fb[0] = 1'b0;
          fb[8:1] = cur.d;
`ifdef UART_TX_PARITY_EN
          fb[9] = ^cur.d;
          nb = 11;
`else
          nb = 10;
`endif
          mon_act = 1'b1;
          bitn = 0;
          k = 0;
        end
      end
      if (mon_act) begin
        chk($sformatf("bit%0d_d%0h", bitn, cur.d), 32'(tx), 32'(fb[bitn]));
        k++;
        if (k == cur.div) begin
          k = 0;
          bitn++;
          if (bitn == nb) begin
            mon_act = 1'b0;
            last_end = cyc;
            nframes++;
          end
        end
      end
    end
  end

  initial begin
    resetb   = 1'b0;
    enable   = 1'b0;
    clk_div  = 16'd4;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick;
    tick;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    resetb = 1'b1;
    tick;

    // basic frame and start latency
    enable = 1'b1;
    push(8'h55, 4, 1'b0);
    @(negedge clock);
    chk("lat_e0_tx", 32'(tx), 32'd1);
    chk("lat_e0_lvl", 32'(fifo_level), 32'd1);
    @(negedge clock);
    chk("lat_e1_tx", 32'(tx), 32'd1);
    @(negedge clock);
    chk("lat_e2_tx", 32'(tx), 32'd0);
    chk("lat_e2_lvl", 32'(fifo_level), 32'd0);
    repeat (39) @(negedge clock);
    chk("busy_last_cycle", 32'(busy), 32'd1);
    @(negedge clock);
    chk("busy_after_40", 32'(busy), 32'd0);
    tick;

    // back-to-back frames
    enable  = 1'b0;
    clk_div = 16'd6;
    push(8'hA3, 6, 1'b0);
    push(8'h0F, 6, 1'b1);
    push(8'hFF, 6, 1'b1);
    chk("b2b_lvl3", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    for (int e = 2; e >= 0; e--) begin
      wait_lvl_change(fifo_level);
      chk("b2b_lvl_step", 32'(fifo_level), 32'(e));
    end
    wait_idle(1000);

    // full FIFO while disabled
    enable  = 1'b0;
    clk_div = 16'd4;
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      chk("full_ready", 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) begin
        e.d = in_data;
        e.div = 4;
        e.gap0 = (i > 0);
        sb.push_back(e);
      end
      tick;
    end
    in_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ready_hold", 32'(in_ready), 32'd0);
    n0 = nframes;
    enable = 1'b1;
    wait_idle(3000);
    chk("full_frames", 32'(nframes - n0), 32'd8);

    // clamp of a too-small divider
    clk_div = 16'd1;
    push(8'h3C, 4, 1'b0);
    wait_idle(500);

    // divider change mid-frame applies at the next frame start
    enable  = 1'b0;
    clk_div = 16'd4;
    push(8'h5A, 4, 1'b0);
    push(8'hC6, 10, 1'b1);
    enable = 1'b1;
    wait_bit(3);
    clk_div = 16'd10;
    wait_idle(1000);

    // dropping enable mid-frame completes the frame then idles
    enable  = 1'b0;
    clk_div = 16'd5;
    push(8'h81, 5, 1'b0);
    push(8'h42, 5, 1'b0);
    enable = 1'b1;
    wait_bit(5);
    enable = 1'b0;
    n0 = nframes;
    wait_frames(n0 + 1);
    repeat (50) tick;
    chk("dis_level", 32'(fifo_level), 32'd1);
    chk("dis_tx_idle", 32'(tx), 32'd1);
    chk("dis_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    wait_idle(500);

    // reset mid-frame aborts and discards
    enable  = 1'b0;
    clk_div = 16'd4;
    push(8'hC3, 4, 1'b0);
    push(8'h99, 4, 1'b0);
    enable = 1'b1;
    wait_bit(4);
    resetb = 1'b0;
    tick;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    resetb = 1'b1;
    sb.delete();
    repeat (60) tick;
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // parity byte (10 or 11 bit times depending on build)
    push(8'h07, 4, 1'b0);
    wait_idle(500);
    chk("end_level", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
